// File: rtl/stoch_im2col_sequencer.sv
// Streams the im2col expansion of one captured signed stochastic frame (plus/minus
// bit planes), one zero-padded patch row per valid/ready handshake, in raster order.
module stoch_im2col_sequencer #(
  parameter int IM_HEIGHT = 4,
  parameter int IM_WIDTH  = 4,
  parameter int CHANNELS  = 2,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 1,
  parameter int PAD_W     = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1,
  localparam int OUT_H      = (IM_HEIGHT + 2*PAD_H - KERNEL_H) / STRIDE_H + 1,
  localparam int OUT_W      = (IM_WIDTH + 2*PAD_W - KERNEL_W) / STRIDE_W + 1,
  localparam int COL_HEIGHT = OUT_H * OUT_W,
  localparam int COL_WIDTH  = KERNEL_H * KERNEL_W * CHANNELS,
  localparam int RW         = (COL_HEIGHT > 1) ? $clog2(COL_HEIGHT) : 1
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_p,
  input  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] im_m,
  output logic [COL_WIDTH-1:0]                          patch_p,
  output logic [COL_WIDTH-1:0]                          patch_m,
  output logic [RW-1:0]                                 patch_row,
  output logic                                          patch_valid,
  input  logic                                          patch_ready,
  output logic                                          patch_last,
  output logic                                          busy,
  output logic                                          done
);

  localparam int YW  = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
  localparam int XW  = (IM_WIDTH  > 1) ? $clog2(IM_WIDTH)  : 1;
  localparam int CHW = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;
  localparam int BW  = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;

  typedef logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0] img_t;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  // Window origin may sit in the padding, so indices are signed before the range test.
  function automatic logic [COL_WIDTH-1:0] build_patch(input img_t img, input int oy, input int ox);
    logic [COL_WIDTH-1:0] p;
    int y;
    int x;
    p = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int kr = 0; kr < KERNEL_H; kr++) begin
        for (int kc = 0; kc < KERNEL_W; kc++) begin
          y = oy * STRIDE_H - PAD_H + kr;
          x = ox * STRIDE_W - PAD_W + kc;
          if (y >= 0 && y < IM_HEIGHT && x >= 0 && x < IM_WIDTH)
            p[BW'(kc + kr*KERNEL_W + ch*KERNEL_H*KERNEL_W)] = img[YW'(y)][XW'(x)][CHW'(ch)];
        end
      end
    end
    return p;
  endfunction

  state_t               state_q;
  img_t                 img_p_q, img_m_q;
  logic [RW-1:0]        ox_q, oy_q, row_q;
  logic [COL_WIDTH-1:0] patch_p_q, patch_m_q;
  logic                 valid_q, last_q, busy_q, done_q;

  logic [RW-1:0]        ox_d, oy_d, row_d;
  logic [COL_WIDTH-1:0] patch_p_d, patch_m_d;
  logic                 last_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    ox_d  = ox_q + 1'b1;
    oy_d  = oy_q;
    if (ox_q == RW'(OUT_W - 1)) begin
      ox_d = '0;
      oy_d = oy_q + 1'b1;
    end
    row_d     = row_q + 1'b1;
    last_d    = (row_d == RW'(COL_HEIGHT - 1));
    patch_p_d = build_patch(img_p_q, int'(oy_d), int'(ox_d));
    patch_m_d = build_patch(img_m_q, int'(oy_d), int'(ox_d));
  end

  // NOTE: state uses non-blocking assignments only; the captured image is reset too, since
  // the frame must read as all-zero until the first start.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      img_p_q   <= '0;
      img_m_q   <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      row_q     <= '0;
      patch_p_q <= '0;
      patch_m_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            img_p_q   <= im_p;
            img_m_q   <= im_m;
            patch_p_q <= build_patch(im_p, 0, 0);
            patch_m_q <= build_patch(im_m, 0, 0);
            ox_q      <= '0;
            oy_q      <= '0;
            row_q     <= '0;
            valid_q   <= 1'b1;
            last_q    <= (COL_HEIGHT == 1);
            busy_q    <= 1'b1;
            state_q   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (valid_q && patch_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              ox_q      <= ox_d;
              oy_q      <= oy_d;
              row_q     <= row_d;
              patch_p_q <= patch_p_d;
              patch_m_q <= patch_m_d;
              last_q    <= last_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign patch_p     = patch_p_q;
  assign patch_m     = patch_m_q;
  assign patch_row   = row_q;
  assign patch_valid = valid_q;
  assign patch_last  = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/stoch_im2col_sequencer.md
Name: stoch_im2col_sequencer

Overview:
- Serialises the im2col transform of one signed stochastic frame (plus/minus bit planes) into one patch row per handshake.
- On start, captures one stochastic sample of the image and then walks every output position in raster order.
- Each emitted patch is a KERNEL_H*KERNEL_W*CHANNELS-bit p/m pair with zero padding.
- Feeds the downstream stochastic dot-product array one row at a time, replacing a fully parallel im2col.

Parameters:
- IM_HEIGHT, 4, input image rows.
- IM_WIDTH, 4, input image columns.
- CHANNELS, 2, input channels.
- KERNEL_H, 3, kernel rows.
- KERNEL_W, 3, kernel columns.
- PAD_H, 1, zero rows added top and bottom.
- PAD_W, 1, zero columns added left and right.
- STRIDE_H, 1, vertical stride (>=1).
- STRIDE_W, 1, horizontal stride (>=1).
- Derived: OUT_H=(IM_HEIGHT+2*PAD_H-KERNEL_H)/STRIDE_H+1; OUT_W likewise; COL_HEIGHT=OUT_H*OUT_W; COL_WIDTH=KERNEL_H*KERNEL_W*CHANNELS; RW=max(1,$clog2(COL_HEIGHT)).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- start  input  1  begin a frame; honoured only in IDLE.
- abort  input  1  synchronous cancel of the current frame.
- im_p  input  [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0]  plus bit plane.
- im_m  input  same as im_p  minus bit plane.
- patch_p  output  COL_WIDTH  plus bits of the current patch.
- patch_m  output  COL_WIDTH  minus bits of the current patch.
- patch_row  output  RW  output row index = oy*OUT_W+ox.
- patch_valid  output  1  patch outputs valid.
- patch_ready  input  1  downstream accepts the patch.
- patch_last  output  1  asserted with the final patch (patch_row==COL_HEIGHT-1).
- busy  output  1  high in STREAM.
- done  output  1  one-cycle pulse after the last patch is accepted.

Behaviour:
- Reset (nRST low, asynchronous): state=IDLE; all outputs, counters and captured image registers are 0.
- States: IDLE, STREAM, DONE.
  - IDLE: start=1 captures im_p/im_m into internal registers, loads patch 0, sets oy=ox=0, and moves to STREAM. patch_valid=1 on the following cycle (latency 1).
  - STREAM: a patch transfers on patch_valid&patch_ready. On the same edge ox increments; when ox wraps from OUT_W-1 to 0, oy increments. The next patch is registered, so valid stays high with no bubble.
  - A transfer with patch_last=1 moves STREAM to DONE; patch_valid drops.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Patch bit mapping: bit kc+kr*KERNEL_W+ch*KERNEL_H*KERNEL_W = image[y][x][ch], where y=oy*STRIDE_H-PAD_H+kr and x=ox*STRIDE_W-PAD_W+kc.
  - If y is outside 0..IM_HEIGHT-1 or x is outside 0..IM_WIDTH-1, the bit is 0 in both patch_p and patch_m.
- Index arithmetic uses signed integers wide enough for -PAD to IM+PAD.
- Backpressure: while patch_valid=1 and patch_ready=0, patch_p, patch_m, patch_row and patch_last are held stable.
- start is ignored in STREAM and DONE. Input changes after capture do not affect the frame.
- abort=1 in STREAM or DONE: next state is IDLE; valid, last and busy go to 0; no done pulse.
- abort has priority over a simultaneous transfer.
- abort together with start in IDLE: abort wins; the frame does not start.
- Degenerate COL_HEIGHT=1: patch 0 carries patch_last=1.
- Output registers are purely sequential: patch_valid and done have no combinational path from patch_ready.

Test Plan:
- Defaults, im_p all 1, im_m all 0, ready tied 1 -> 16 patches on consecutive cycles, rows 0..15.
  - Row 0 patch_p popcount = 8 (4 per channel); row 5 popcount = 18.
  - patch_m is always 0; patch_last only on row 15; done pulses the cycle after.
- Defaults, single bit im_p[2][3][1]=1 -> exactly 6 patches are nonzero (oy 1..3, ox 2..3).
  - Row 11 (oy=2, ox=3) has only bit 13 set.
- Backpressure: ready=0 for 3 cycles while row 2 is presented -> outputs stable for 3 cycles; row 3 follows one cycle after ready rises.
  - Total 16 transfers, no duplicates or drops.
- Abort after row 7 is accepted -> next cycle valid=0, busy=0, no done.
  - A new start yields row 0 from the newly captured image.
- Mid-frame nRST pulse -> all outputs 0 immediately; start after release restarts at row 0.
  - start during STREAM is ignored: frame length stays 16.
- IM 5x5, CHANNELS=1, PAD 0, stride 2 -> COL_HEIGHT=4, COL_WIDTH=9.
  - Row 3 patch_p equals image[2..4][2..4]; patch_last on row 3.
